// File: rtl/icache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icache_pkg                                                           |
// | Shared geometry and state encoding for instruction-line fills.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package icache_pkg;

    localparam int LINE_BITS       = 256;
    localparam int WORDS_PER_LINE  = 8;
    localparam int BLOCK_ADDR_BITS = 9;
    localparam int WORD_ADDR_BITS  = 12;
    localparam int WORD_BITS       = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/line_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | line_assembler                                                       |
// | 256-bit line register with per-slot word write and a clear.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module line_assembler
    import icache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_wr_en,
    input  logic [2:0]           i_slot,
    input  logic [WORD_BITS-1:0] i_wdata,
    output logic [LINE_BITS-1:0] o_line_next
);

    logic [LINE_BITS-1:0] r_line;

    // The next value is exported so the final word can be captured in the same edge.
    always_comb begin
        o_line_next = r_line;
        if (i_clear) begin
            o_line_next = '0;
        end else if (i_wr_en) begin
            o_line_next[{i_slot, 5'b00000} +: WORD_BITS] = i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_line <= '0;
        end else begin
            r_line <= o_line_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_line_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_line_responder                                           |
// | Fills 256-bit icache lines from eight word reads, with a one-entry   |
// | last-line buffer. Revision: 1.0                                      |
// +----------------------------------------------------------------------+
module instruction_line_responder
    import icache_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int BUF_ENABLE      = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       readmem,
    input  logic [BLOCK_ADDR_BITS-1:0] mem_block_addr,
    input  logic                       flush,
    output logic [LINE_BITS-1:0]       new_line,
    output logic                       line_ready,
    output logic                       busy,
    output logic                       wmem_req,
    output logic [WORD_ADDR_BITS-1:0]  wmem_addr,
    input  logic                       wmem_gnt,
    input  logic                       wmem_rvalid,
    input  logic [WORD_BITS-1:0]       wmem_rdata
);

    localparam logic [3:0] c_MAX_OUT = 4'(MAX_OUTSTANDING);
    localparam logic [3:0] c_WORDS   = 4'(WORDS_PER_LINE);
    localparam logic       c_BUF_EN  = (BUF_ENABLE != 0);

    logic [1:0]                 r_state,     w_state_d;
    logic [BLOCK_ADDR_BITS-1:0] r_blk,       w_blk_d;
    logic [3:0]                 r_issue_cnt, w_issue_cnt_d;
    logic [3:0]                 r_resp_cnt,  w_resp_cnt_d;
    logic                       r_withdrawn, w_withdrawn_d;
    logic                       r_flush_pend, w_flush_pend_d;
    logic                       r_buf_valid, w_buf_valid_d;
    logic [BLOCK_ADDR_BITS-1:0] r_buf_tag,   w_buf_tag_d;
    logic [LINE_BITS-1:0]       r_buf_line,  w_buf_line_d;
    logic [LINE_BITS-1:0]       r_new_line,  w_new_line_d;
    logic                       r_line_ready, w_line_ready_d;
    logic                       r_busy,      w_busy_d;

    logic                 w_req;
    logic                 w_issue;
    logic                 w_resp;
    logic                 w_hit;
    logic                 w_asm_clear;
    logic [LINE_BITS-1:0] w_line_next;

    assign w_req = (r_state == FILL) && (r_issue_cnt < c_WORDS) &&
                   ((r_issue_cnt - r_resp_cnt) < c_MAX_OUT);
    assign w_issue     = w_req && wmem_gnt;
    assign w_resp      = (r_state == FILL) && wmem_rvalid && (r_resp_cnt < c_WORDS);
    assign w_hit       = c_BUF_EN && r_buf_valid && (r_buf_tag == mem_block_addr) && !flush;
    assign w_asm_clear = (r_state == IDLE) && readmem && !w_hit;

    line_assembler u_line_assembler (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_asm_clear),
        .i_wr_en     (w_resp),
        .i_slot      (r_resp_cnt[2:0]),
        .i_wdata     (wmem_rdata),
        .o_line_next (w_line_next)
    );

    always_comb begin
        w_state_d      = r_state;
        w_blk_d        = r_blk;
        w_issue_cnt_d  = r_issue_cnt;
        w_resp_cnt_d   = r_resp_cnt;
        w_withdrawn_d  = r_withdrawn;
        w_flush_pend_d = r_flush_pend;
        w_buf_valid_d  = r_buf_valid;
        w_buf_tag_d    = r_buf_tag;
        w_buf_line_d   = r_buf_line;
        w_new_line_d   = r_new_line;
        w_line_ready_d = 1'b0;
        w_busy_d       = r_busy;

        case (r_state)
            IDLE: begin
                if (flush) begin
                    w_buf_valid_d = 1'b0;
                end
                if (readmem) begin
                    w_blk_d  = mem_block_addr;
                    w_busy_d = 1'b1;
                    if (w_hit) begin
                        w_new_line_d   = r_buf_line;
                        w_line_ready_d = 1'b1;
                        w_state_d      = DONE;
                    end else begin
                        w_issue_cnt_d  = '0;
                        w_resp_cnt_d   = '0;
                        w_withdrawn_d  = 1'b0;
                        w_flush_pend_d = 1'b0;
                        w_state_d      = FILL;
                    end
                end
            end

            FILL: begin
                if (w_issue) begin
                    w_issue_cnt_d = r_issue_cnt + 4'd1;
                end
                if (w_resp) begin
                    w_resp_cnt_d = r_resp_cnt + 4'd1;
                end
                if (!readmem) begin
                    w_withdrawn_d = 1'b1;
                end
                if (flush) begin
                    w_flush_pend_d = 1'b1;
                    w_buf_valid_d  = 1'b0;
                end
                // Last word arrives: the line is complete this edge.
                if (w_resp && (r_resp_cnt == c_WORDS - 4'd1)) begin
                    w_new_line_d   = w_line_next;
                    w_buf_line_d   = w_line_next;
                    w_buf_tag_d    = r_blk;
                    w_buf_valid_d  = c_BUF_EN && !r_flush_pend && !flush;
                    w_line_ready_d = !r_withdrawn && readmem;
                    w_state_d      = DONE;
                end
            end

            DONE: begin
                if (flush) begin
                    w_buf_valid_d = 1'b0;
                end
                w_busy_d  = 1'b0;
                w_state_d = IDLE;
            end

            default: begin
                w_busy_d  = 1'b0;
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_blk        <= '0;
            r_issue_cnt  <= '0;
            r_resp_cnt   <= '0;
            r_withdrawn  <= 1'b0;
            r_flush_pend <= 1'b0;
            r_buf_valid  <= 1'b0;
            r_buf_tag    <= '0;
            r_buf_line   <= '0;
            r_new_line   <= '0;
            r_line_ready <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_blk        <= w_blk_d;
            r_issue_cnt  <= w_issue_cnt_d;
            r_resp_cnt   <= w_resp_cnt_d;
            r_withdrawn  <= w_withdrawn_d;
            r_flush_pend <= w_flush_pend_d;
            r_buf_valid  <= w_buf_valid_d;
            r_buf_tag    <= w_buf_tag_d;
            r_buf_line   <= w_buf_line_d;
            r_new_line   <= w_new_line_d;
            r_line_ready <= w_line_ready_d;
            r_busy       <= w_busy_d;
        end
    end

    assign new_line   = r_new_line;
    assign line_ready = r_line_ready;
    assign busy       = r_busy;
    assign wmem_req   = w_req;
    assign wmem_addr  = w_req ? {r_blk, r_issue_cnt[2:0]} : '0;

endmodule
`default_nettype wire
